// File: rtl/divisor_pkg.sv
// Shared types and default sizes for the divider scheduler.
package divisor_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      ISSUE = 2'd1,
      WAIT  = 2'd2,
      RESP  = 2'd3
   } sched_state_t;

   localparam int DIV_W    = 32;
   localparam int DIV_NREQ = 4;

endpackage

// File: rtl/divisor_rr_arbitro.sv
// Rotating-priority encoder: grants the first requester found after ptr,
// wrapping modulo N_REQ, so the last winner has the lowest priority.
module divisor_rr_arbitro import divisor_pkg::*; #(
   parameter int N_REQ = DIV_NREQ,
   parameter int PW    = $clog2(N_REQ)
) (
   input  logic [N_REQ-1:0] req,
   input  logic [PW-1:0]    ptr,
   output logic             gnt_valid,
   output logic [PW-1:0]    gnt_idx
);

   logic [PW-1:0] cand;

   // Walk candidates from farthest to nearest so the nearest set bit after ptr wins
   always_comb begin
      gnt_valid = 1'b0;
      gnt_idx   = '0;
      cand      = '0;
      for (int k = N_REQ; k >= 1; k--) begin
         cand = PW'((int'(ptr) + k) % N_REQ);
         if (req[cand]) begin
            gnt_valid = 1'b1;
            gnt_idx   = cand;
         end
      end
   end

endmodule

// File: rtl/divisor_planificador.sv
// Round-robin scheduler sharing one iterative signed divider among N_REQ
// requesters. Zero divisors are answered locally without starting the divider.
module divisor_planificador import divisor_pkg::*; #(
   parameter int N_REQ   = DIV_NREQ,
   parameter int tamanyo = DIV_W
) (
   input  logic                            CLK,
   input  logic                            RSTa,
   input  logic [N_REQ-1:0]                req,
   input  logic [N_REQ-1:0][tamanyo-1:0]   num,
   input  logic [N_REQ-1:0][tamanyo-1:0]   den,
   output logic [N_REQ-1:0]                ack,
   output logic [tamanyo-1:0]              coc,
   output logic [tamanyo-1:0]              res,
   output logic                            err,
   output logic                            busy,
   output logic                            div_start,
   output logic [tamanyo-1:0]              div_num,
   output logic [tamanyo-1:0]              div_den,
   input  logic [tamanyo-1:0]              div_coc,
   input  logic [tamanyo-1:0]              div_res,
   input  logic                            div_done
);

   localparam int PW = $clog2(N_REQ);
   localparam logic [N_REQ-1:0] ACK_ONE = {{(N_REQ-1){1'b0}}, 1'b1};

   sched_state_t         state_q;
   logic [PW-1:0]        ptr_q;
   logic [PW-1:0]        gIdx_q;
   logic [N_REQ-1:0]     ack_q;
   logic [tamanyo-1:0]   coc_q;
   logic [tamanyo-1:0]   res_q;
   logic                 err_q;
   logic                 start_q;
   logic [tamanyo-1:0]   numLat_q;
   logic [tamanyo-1:0]   denLat_q;

   logic                 gntValid;
   logic [PW-1:0]        gntIdx;
   logic [tamanyo-1:0]   selNum;
   logic [tamanyo-1:0]   selDen;

   divisor_rr_arbitro #(
      .N_REQ (N_REQ),
      .PW    (PW)
   ) uArbitro (
      .req       (req),
      .ptr       (ptr_q),
      .gnt_valid (gntValid),
      .gnt_idx   (gntIdx)
   );

   assign selNum = num[gntIdx];
   assign selDen = den[gntIdx];

   // Scheduler FSM: grant, launch divider, collect result, acknowledge winner
   always_ff @(posedge CLK or negedge RSTa) begin
      if (!RSTa) begin
         state_q  <= IDLE;
         ptr_q    <= PW'(N_REQ - 1);
         gIdx_q   <= '0;
         ack_q    <= '0;
         coc_q    <= '0;
         res_q    <= '0;
         err_q    <= 1'b0;
         start_q  <= 1'b0;
         numLat_q <= '0;
         denLat_q <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (gntValid) begin
                  gIdx_q   <= gntIdx;
                  numLat_q <= selNum;
                  denLat_q <= selDen;
                  if (selDen == '0) begin
                     coc_q   <= '0;
                     res_q   <= selNum;
                     err_q   <= 1'b1;
                     ack_q   <= ACK_ONE << gntIdx;
                     state_q <= RESP;
                  end else begin
                     start_q <= 1'b1;
                     state_q <= ISSUE;
                  end
               end
            end
            ISSUE: begin
               start_q <= 1'b0;
               state_q <= WAIT;
            end
            WAIT: begin
               if (div_done) begin
                  coc_q   <= div_coc;
                  res_q   <= div_res;
                  err_q   <= 1'b0;
                  ack_q   <= ACK_ONE << gIdx_q;
                  state_q <= RESP;
               end
            end
            RESP: begin
               ack_q   <= '0;
               ptr_q   <= gIdx_q;
               state_q <= IDLE;
            end
            default: begin
               state_q <= IDLE;
            end
         endcase
      end
   end

   assign ack       = ack_q;
   assign coc       = coc_q;
   assign res       = res_q;
   assign err       = err_q;
   assign busy      = (state_q != IDLE);
   assign div_start = start_q;
   assign div_num   = numLat_q;
   assign div_den   = denLat_q;

endmodule

// File: tb/tb_divisor_planificador.sv
// Bench for divisor_planificador with a behavioural iterative divider
// of randomized latency attached to the divider port.
module tb_divisor_planificador;
   import divisor_pkg::*;

   localparam int N = 4;
   localparam int W = 32;

   logic                 CLK = 1'b0;
   logic                 RSTa;
   logic [N-1:0]         req;
   logic [N-1:0][W-1:0]  num;
   logic [N-1:0][W-1:0]  den;
   logic [N-1:0]         ack;
   logic [W-1:0]         coc;
   logic [W-1:0]         res;
   logic                 err;
   logic                 busy;
   logic                 div_start;
   logic [W-1:0]         div_num;
   logic [W-1:0]         div_den;
   logic [W-1:0]         div_coc;
   logic [W-1:0]         div_res;
   logic                 div_done;

   int checks = 0;
   int errors = 0;

   int   divForceD    = 0;
   int   divLastD     = 0;
   int   divCnt       = 0;
   int   startCount   = 0;
   logic divPending   = 1'b0;
   logic spuriousDone = 1'b0;
   logic [W-1:0] pN, pD;

   typedef struct {
      int         idx;
      logic [W-1:0] n;
      logic [W-1:0] d;
      logic [W-1:0] expCoc;
      logic [W-1:0] expRes;
      logic       expErr;
   } vec_t;

   vec_t vecs[7];

   divisor_planificador #(
      .N_REQ   (N),
      .tamanyo (W)
   ) dut (
      .CLK       (CLK),
      .RSTa      (RSTa),
      .req       (req),
      .num       (num),
      .den       (den),
      .ack       (ack),
      .coc       (coc),
      .res       (res),
      .err       (err),
      .busy      (busy),
      .div_start (div_start),
      .div_num   (div_num),
      .div_den   (div_den),
      .div_coc   (div_coc),
      .div_res   (div_res),
      .div_done  (div_done)
   );

   always #5 CLK = ~CLK;

   task automatic checkOutput(input string name, input logic [W-1:0] actual, input logic [W-1:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, actual, expected);
      end
   endtask

   task automatic applyStimulus(input int idx, input logic [W-1:0] n, input logic [W-1:0] d);
      num[idx] = n;
      den[idx] = d;
      req[idx] = 1'b1;
   endtask

   task automatic refDiv(input logic [W-1:0] n, input logic [W-1:0] d,
                         output logic [W-1:0] c, output logic [W-1:0] r, output logic e);
      if (d == '0) begin
         c = '0;
         r = n;
         e = 1'b1;
      end else begin
         c = $signed(n) / $signed(d);
         r = $signed(n) % $signed(d);
         e = 1'b0;
      end
   endtask

   function automatic int nextWinner(input logic [N-1:0] m, input int last);
      for (int k = 1; k <= N; k++) begin
         if (m[(last + k) % N]) return (last + k) % N;
      end
      return -1;
   endfunction

   task automatic waitAck(output int cycles, output logic ok);
      cycles = 0;
      ok     = 1'b0;
      repeat (60) begin
         @(posedge CLK); #1;
         cycles++;
         if (ack != '0) begin
            ok = 1'b1;
            break;
         end
      end
      if (!ok) checkOutput("ack_timeout", 32'd0, 32'd1);
   endtask

   task automatic doReset();
      RSTa = 1'b0;
      req  = '0;
      repeat (2) @(posedge CLK);
      #1;
      RSTa = 1'b1;
   endtask

   // Behavioural divider: D cycles after Start it pulses Done with C-style signed results
   initial begin : dividerModel
      div_done = 1'b0;
      div_coc  = '0;
      div_res  = '0;
      forever begin
         @(posedge CLK); #1;
         if (!RSTa) begin
            divPending = 1'b0;
            div_done   = 1'b0;
            continue;
         end
         div_done = 1'b0;
         if (spuriousDone) begin
            div_done     = 1'b1;
            div_coc      = 32'hDEAD_BEEF;
            div_res      = 32'h1234_5678;
            spuriousDone = 1'b0;
         end else if (divPending) begin
            divCnt--;
            if (divCnt == 0) begin
               div_done   = 1'b1;
               div_coc    = $signed(pN) / $signed(pD);
               div_res    = $signed(pN) % $signed(pD);
               divPending = 1'b0;
            end
         end
         if (div_start) begin
            checkOutput("div_restart_while_busy", {31'd0, divPending}, 32'd0);
            startCount++;
            pN         = div_num;
            pD         = div_den;
            divLastD   = (divForceD > 0) ? divForceD : int'($urandom_range(1, 6));
            divCnt     = divLastD;
            divPending = 1'b1;
         end
      end
   end

   // Main test sequence
   initial begin : mainTest
      int cyc, sb, expIdx, acks, idleRun, scrambleCnt, scrambleIdx, lastServed, seen;
      logic ok, addNew, eE;
      logic [W-1:0] eC, eR, n, d;
      logic [N-1:0] pendMask;
      logic [W-1:0] opN[N];
      logic [W-1:0] opD[N];

      vecs[0] = '{0, 32'd7,          32'd2,          32'd3,          32'd1,          1'b0};
      vecs[1] = '{1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF,  1'b0};
      vecs[2] = '{2, 32'd5,          32'd0,          32'd0,          32'd5,          1'b1};
      vecs[3] = '{3, 32'd100,        32'hFFFF_FFF9,  32'hFFFF_FFF2,  32'd2,          1'b0};
      vecs[4] = '{0, 32'hFFFF_FF9C,  32'hFFFF_FFF9,  32'd14,         32'hFFFF_FFFE,  1'b0};
      vecs[5] = '{1, 32'h8000_0000,  32'd1,          32'h8000_0000,  32'd0,          1'b0};
      vecs[6] = '{3, 32'hFFFF_FFF9,  32'd0,          32'd0,          32'hFFFF_FFF9,  1'b1};

      RSTa = 1'b0;
      req  = '0;
      num  = '0;
      den  = '0;
      repeat (2) @(posedge CLK);
      #1;
      checkOutput("rst_ack",       {28'd0, ack}, 32'd0);
      checkOutput("rst_coc",       coc, 32'd0);
      checkOutput("rst_res",       res, 32'd0);
      checkOutput("rst_err",       {31'd0, err}, 32'd0);
      checkOutput("rst_busy",      {31'd0, busy}, 32'd0);
      checkOutput("rst_div_start", {31'd0, div_start}, 32'd0);
      checkOutput("rst_div_num",   div_num, 32'd0);
      checkOutput("rst_div_den",   div_den, 32'd0);
      RSTa = 1'b1;
      @(posedge CLK); #1;

      // Table-driven single transactions
      for (int v = 0; v < 7; v++) begin
         sb = startCount;
         applyStimulus(vecs[v].idx, vecs[v].n, vecs[v].d);
         waitAck(cyc, ok);
         if (ok) begin
            checkOutput($sformatf("vec%0d_ack", v), {28'd0, ack}, 32'd1 << vecs[v].idx);
            checkOutput($sformatf("vec%0d_coc", v), coc, vecs[v].expCoc);
            checkOutput($sformatf("vec%0d_res", v), res, vecs[v].expRes);
            checkOutput($sformatf("vec%0d_err", v), {31'd0, err}, {31'd0, vecs[v].expErr});
            checkOutput($sformatf("vec%0d_latency", v), cyc, vecs[v].expErr ? 32'd1 : 32'(2 + divLastD));
            checkOutput($sformatf("vec%0d_starts", v), startCount - sb, vecs[v].expErr ? 32'd0 : 32'd1);
         end
         req[vecs[v].idx] = 1'b0;
         @(posedge CLK); #1;
         checkOutput($sformatf("vec%0d_ack_pulse", v), {28'd0, ack}, 32'd0);
      end

      // Fairness: all four held, expect order 0,1,2,3,0,1
      doReset();
      applyStimulus(0, 32'd20, 32'd3);
      applyStimulus(1, 32'd33, 32'd4);
      applyStimulus(2, 32'hFFFF_FFD1, 32'd5);
      applyStimulus(3, 32'd58, 32'hFFFF_FFFA);
      seen = 0;
      for (int c = 0; c < 200 && seen < 6; c++) begin
         @(posedge CLK); #1;
         if (ack != '0) begin
            checkOutput("fair_onehot", $countones(ack), 32'd1);
            checkOutput($sformatf("fair_order%0d", seen), {28'd0, ack}, 32'd1 << (seen % N));
            refDiv(num[seen % N], den[seen % N], eC, eR, eE);
            checkOutput($sformatf("fair_coc%0d", seen), coc, eC);
            checkOutput($sformatf("fair_res%0d", seen), res, eR);
            seen++;
         end
      end
      req = '0;
      checkOutput("fair_ack_count", seen, 32'd6);
      repeat (2) @(posedge CLK);
      #1;

      // Simultaneous requests 0 and 2 after reset
      doReset();
      applyStimulus(0, 32'd9, 32'd4);
      applyStimulus(2, 32'hFFFF_FFF7, 32'd4);
      seen = 0;
      for (int c = 0; c < 100 && seen < 2; c++) begin
         @(posedge CLK); #1;
         if (ack != '0) begin
            if (seen == 0) begin
               checkOutput("simul_first", {28'd0, ack}, 32'd1);
               checkOutput("simul_coc0", coc, 32'd2);
               checkOutput("simul_res0", res, 32'd1);
               req[0] = 1'b0;
            end else begin
               checkOutput("simul_second", {28'd0, ack}, 32'd4);
               checkOutput("simul_coc2", coc, 32'hFFFF_FFFE);
               checkOutput("simul_res2", res, 32'hFFFF_FFFF);
               req[2] = 1'b0;
            end
            seen++;
         end
      end
      checkOutput("simul_ack_count", seen, 32'd2);

      // A Done pulse while idle must be ignored
      spuriousDone = 1'b1;
      repeat (3) @(posedge CLK);
      #1;
      checkOutput("spurious_ack",  {28'd0, ack}, 32'd0);
      checkOutput("spurious_busy", {31'd0, busy}, 32'd0);
      checkOutput("spurious_coc",  coc, 32'hFFFF_FFFE);

      // Reset while waiting on the divider
      divForceD = 20;
      applyStimulus(1, 32'd50, 32'd7);
      repeat (4) @(posedge CLK);
      #1;
      checkOutput("midwait_busy", {31'd0, busy}, 32'd1);
      RSTa = 1'b0;
      req  = '0;
      #1;
      checkOutput("midwait_rst_ack",   {28'd0, ack}, 32'd0);
      checkOutput("midwait_rst_coc",   coc, 32'd0);
      checkOutput("midwait_rst_res",   res, 32'd0);
      checkOutput("midwait_rst_err",   {31'd0, err}, 32'd0);
      checkOutput("midwait_rst_busy",  {31'd0, busy}, 32'd0);
      checkOutput("midwait_rst_start", {31'd0, div_start}, 32'd0);
      checkOutput("midwait_rst_dnum",  div_num, 32'd0);
      checkOutput("midwait_rst_dden",  div_den, 32'd0);
      repeat (2) @(posedge CLK);
      #1;
      RSTa = 1'b1;
      divForceD = 0;
      seen = 0;
      repeat (25) begin
         @(posedge CLK); #1;
         if (ack != '0) seen++;
      end
      checkOutput("midwait_no_ack", seen, 32'd0);
      applyStimulus(3, 32'hFFFF_FFCE, 32'd7);
      waitAck(cyc, ok);
      if (ok) begin
         checkOutput("after_rst_ack", {28'd0, ack}, 32'd8);
         checkOutput("after_rst_coc", coc, 32'hFFFF_FFF9);
         checkOutput("after_rst_res", res, 32'hFFFF_FFFF);
         checkOutput("after_rst_err", {31'd0, err}, 32'd0);
      end
      req = '0;

      // Randomized traffic against the round-robin reference model
      doReset();
      pendMask    = '0;
      lastServed  = N - 1;
      acks        = 0;
      idleRun     = 0;
      scrambleCnt = -1;
      scrambleIdx = 0;
      for (int i = 0; i < N; i++) begin
         opN[i] = '0;
         opD[i] = '0;
      end
      for (int c = 0; c < 20000 && acks < 150; c++) begin
         @(posedge CLK); #1;
         addNew = 1'b0;
         if (ack != '0) begin
            expIdx = nextWinner(pendMask, lastServed);
            checkOutput("rnd_onehot", $countones(ack), 32'd1);
            checkOutput("rnd_ack", {28'd0, ack}, (expIdx < 0) ? 32'd0 : 32'd1 << expIdx);
            if (expIdx >= 0) begin
               refDiv(opN[expIdx], opD[expIdx], eC, eR, eE);
               checkOutput("rnd_coc", coc, eC);
               checkOutput("rnd_res", res, eR);
               checkOutput("rnd_err", {31'd0, err}, {31'd0, eE});
               pendMask[expIdx] = 1'b0;
               req[expIdx]      = 1'b0;
               lastServed       = expIdx;
            end
            acks++;
            idleRun     = 0;
            scrambleCnt = -1;
            addNew      = 1'b1;
         end else begin
            idleRun++;
            if (pendMask == '0) addNew = 1'b1;
            if (idleRun > 40 && pendMask != '0) begin
               checkOutput("rnd_ack_timeout", 32'd0, 32'd1);
               break;
            end
         end
         for (int i = 0; i < N; i++) begin
            if (!pendMask[i]) begin
               num[i] = $urandom;
               den[i] = $urandom;
            end
         end
         if (scrambleCnt > 0) begin
            scrambleCnt--;
            if (scrambleCnt == 0) begin
               num[scrambleIdx] = $urandom;
               den[scrambleIdx] = $urandom;
            end
         end
         if (addNew) begin
            for (int i = 0; i < N; i++) begin
               if (!pendMask[i] && $urandom_range(0, 2) == 0) begin
                  n = $urandom;
                  d = 32'($urandom_range(0, 40)) - 32'd20;
                  if ($urandom_range(0, 3) == 0) d = $urandom;
                  if (n == 32'h8000_0000 && d == 32'hFFFF_FFFF) d = 32'd1;
                  opN[i] = n;
                  opD[i] = d;
                  applyStimulus(i, n, d);
                  pendMask[i] = 1'b1;
               end
            end
            if (pendMask != '0) begin
               scrambleIdx = nextWinner(pendMask, lastServed);
               scrambleCnt = (ack != '0) ? 2 : 1;
            end
         end
      end
      checkOutput("rnd_ack_count", (acks >= 150) ? 32'd1 : 32'd0, 32'd1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
